reg_file_mp: RTL and testbench
==============================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DATA_W, default 32, SHALL set the register width in bits.
REQ-003 Parameter ADDR_W, default 5, SHALL set the address width; depth DEPTH = 2^ADDR_W.
REQ-004 Parameter N_READ, default 2, range 1..4, SHALL set the number of read ports.
REQ-005 Parameter ZERO_REG, default 1, SHALL hardwire entry 0 to zero when set to 1.
REQ-006 Port clk  input  1  is the rising-edge clock for all state.
REQ-007 Port reset  input  1  is the synchronous active-high reset.
REQ-008 Port readReg  input  N_READ*ADDR_W  carries the packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
REQ-009 Port readData  output  N_READ*DATA_W  carries the packed read data; port k uses bits [k*DATA_W +: DATA_W].
REQ-010 Port writeReg  input  ADDR_W  is the write address.
REQ-011 Port writeData  input  DATA_W  is the write data.
REQ-012 Port regWrite  input  1  is the write enable.
REQ-013 Port clearReq  input  1  requests a full-array clear.
REQ-014 Port busy  output  1  is high while a clear sweep is in progress.

Function
REQ-015 The storage SHALL be an array of DEPTH entries of DATA_W bits.
REQ-016 The FSM SHALL have exactly two states, CLEAR and IDLE, plus a clear pointer clrPtr of ADDR_W bits.
REQ-017 In CLEAR, each clock SHALL write 0 to entry clrPtr and then increment clrPtr.
REQ-018 In CLEAR with clrPtr==DEPTH-1, the next state SHALL be IDLE and clrPtr SHALL wrap to 0.
REQ-019 In IDLE with clearReq=1, the next state SHALL be CLEAR with clrPtr=0; any regWrite in that same cycle SHALL still be performed.
REQ-020 clearReq SHALL be ignored in CLEAR; the sweep SHALL neither restart nor extend.
REQ-021 busy SHALL be 1 exactly when the state is CLEAR; a sweep lasts DEPTH cycles.
REQ-022 In IDLE with regWrite=1, Bank[writeReg] SHALL take writeData at the rising edge.
REQ-023 With ZERO_REG=1, writes to writeReg==0 SHALL be discarded.
REQ-024 In CLEAR, regWrite SHALL be ignored and no write SHALL occur.
REQ-025 Reads SHALL be combinational, and readData[k] SHALL equal Bank[readReg[k]].
REQ-026 Bypass: in IDLE, if regWrite=1 and writeReg==readReg[k] (and that address is nonzero when ZERO_REG=1), readData[k] SHALL equal writeData in the same cycle.
REQ-027 With ZERO_REG=1, a read of address 0 SHALL return 0 regardless of array content.
REQ-028 While busy=1, every readData[k] SHALL be 0.
REQ-029 All read ports SHALL be independent, and the same address on several ports SHALL return identical data.

Reset
REQ-030 With reset=1 at a rising edge, the state SHALL become CLEAR, clrPtr SHALL become 0, and busy SHALL be 1 from the next cycle onward.
REQ-031 Reset SHALL override clearReq and regWrite, and reset asserted mid-sweep SHALL restart the sweep at entry 0.
REQ-032 After reset deasserts, busy SHALL remain 1 for DEPTH cycles, and all entries SHALL then read 0.
REQ-033 readData SHALL be 0 throughout reset and the following sweep.

Verification
REQ-034 Reset pulse, default parameters -> busy=1 for 32 cycles, then 0; all 32 addresses read 0.
REQ-035 Write 0xDEADBEEF to reg 7, then read it on port 0 and port 1 -> both return 0xDEADBEEF in the next cycle.
REQ-036 In one cycle, write 0x12345678 to reg 3 with readReg[0]=3 -> readData[0]=0x12345678 in the same cycle (bypass).
REQ-037 Write 0xFFFFFFFF to reg 0 (ZERO_REG=1) -> reg 0 reads 0; same write with ZERO_REG=0 -> reads 0xFFFFFFFF.
REQ-038 Fill regs 1..31, pulse clearReq, and pulse regWrite mid-sweep -> busy for 32 cycles, the write is ignored, and all entries read 0 afterwards.
REQ-039 Assert reset at sweep cycle 10 -> the sweep restarts, and busy stays 1 for 32 cycles after reset deasserts.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with a single write port, write-to-read bypass
// and a background clear sweep that zeroes every entry, one per clock.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_READ   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_READ*ADDR_W-1:0] readReg,
  output logic [N_READ*DATA_W-1:0] readData,
  input  logic [ADDR_W-1:0]        writeReg,
  input  logic [DATA_W-1:0]        writeData,
  input  logic                     regWrite,
  input  logic                     clearReq,
  output logic                     busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   clr_ptr_reg, clr_ptr_next;

  logic [DATA_W-1:0]   bank [DEPTH];

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                user_wr;
  logic                write_to_zero;

  // A user write only lands in IDLE, and never on the hardwired zero entry.
  assign write_to_zero = (ZERO_REG != 0) && (writeReg == '0);
  assign user_wr       = (state_reg == IDLE) && regWrite && !write_to_zero;
  assign busy          = (state_reg == CLEAR);

  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    wr_en        = 1'b0;
    wr_addr      = writeReg;
    wr_data      = writeData;
    case (state_reg)
      IDLE: begin
        wr_en = user_wr;
        if (clearReq) begin
          state_next   = CLEAR;
          clr_ptr_next = '0;
        end
      end
      CLEAR: begin
        wr_en        = 1'b1;
        wr_addr      = clr_ptr_reg;
        wr_data      = '0;
        clr_ptr_next = clr_ptr_reg + 1'b1;
        if (clr_ptr_reg == '1) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next   = CLEAR;
        clr_ptr_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= CLEAR;
      clr_ptr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
    end
  end

  // Storage has no reset of its own; the sweep that follows reset zeroes it.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      bank[wr_addr] <= wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_READ; gi++) begin : g_rd
      logic [ADDR_W-1:0] rd_addr;
      logic [DATA_W-1:0] rd_data;

      assign rd_addr = readReg[gi*ADDR_W +: ADDR_W];

      always_comb begin
        rd_data = bank[rd_addr];
        if (user_wr && (writeReg == rd_addr)) begin
          rd_data = writeData;
        end
        if ((ZERO_REG != 0) && (rd_addr == '0)) begin
          rd_data = '0;
        end
        // Array content is stale until the sweep completes, so mask it.
        if (reset || busy) begin
          rd_data = '0;
        end
      end

      assign readData[gi*DATA_W +: DATA_W] = rd_data;
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: two instances (ZERO_REG=1 and 0) share
// stimulus; a per-cycle model check plus directed literal expectations.
module tb_reg_file_mp;

  logic        clk;
  logic        reset;
  logic        regWrite;
  logic        clearReq;
  logic [9:0]  readReg;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [63:0] rd_z, rd_nz;
  logic        busy_z, busy_nz;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .N_READ(2), .ZERO_REG(1)) dut_z (
    .clk(clk), .reset(reset), .readReg(readReg), .readData(rd_z),
    .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
    .clearReq(clearReq), .busy(busy_z)
  );

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .N_READ(2), .ZERO_REG(0)) dut_nz (
    .clk(clk), .reset(reset), .readReg(readReg), .readData(rd_nz),
    .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
    .clearReq(clearReq), .busy(busy_nz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a clear (or reset) zeroes the contents at once and then just counts
  // down the busy window; reads are masked during that window anyway.
  int          sweep_left = 0;
  logic [31:0] mz  [32];
  logic [31:0] mnz [32];

  always @(posedge clk) begin
    if (reset) begin
      sweep_left <= 32;
      for (int i = 0; i < 32; i++) begin
        mz[i]  <= '0;
        mnz[i] <= '0;
      end
    end else if (sweep_left > 0) begin
      sweep_left <= sweep_left - 1;
    end else begin
      if (regWrite) begin
        if (writeReg != 5'd0) mz[writeReg] <= writeData;
        mnz[writeReg] <= writeData;
      end
      if (clearReq) begin
        sweep_left <= 32;
        for (int i = 0; i < 32; i++) begin
          mz[i]  <= '0;
          mnz[i] <= '0;
        end
      end
    end
  end

  function automatic logic [31:0] exp_rd(input bit zr, input logic [4:0] a);
    if (reset || sweep_left > 0) return 32'h0;
    if (zr && a == 5'd0) return 32'h0;
    if (regWrite && writeReg == a) return writeData;
    return zr ? mz[a] : mnz[a];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy_z", {63'd0, busy_z}, {63'd0, sweep_left > 0});
      check("busy_nz", {63'd0, busy_nz}, {63'd0, sweep_left > 0});
      for (int k = 0; k < 2; k++) begin
        check("model_rd_z", {32'd0, rd_z[k*32 +: 32]}, {32'd0, exp_rd(1'b1, readReg[k*5 +: 5])});
        check("model_rd_nz", {32'd0, rd_nz[k*32 +: 32]}, {32'd0, exp_rd(1'b0, readReg[k*5 +: 5])});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic all_zero(input string name);
    for (int i = 0; i < 32; i++) begin
      tick();
      readReg = {5'(31 - i), 5'(i)};
      #2;
      check(name, rd_z, 64'h0);
      check(name, rd_nz, 64'h0);
    end
  endtask

  initial begin
    int n;
    int m;
    logic [4:0] a;
    logic [4:0] prev;

    reset = 1'b1; regWrite = 1'b0; clearReq = 1'b0;
    readReg = '0; writeReg = '0; writeData = '0;

    // Reset pulse, then the post-reset sweep.
    tick();
    tick();
    chk_en = 1'b1;
    check("reset_busy", {63'd0, busy_z}, 64'd1);
    check("reset_rd", rd_z, 64'h0);
    reset = 1'b0;
    n = 0;
    while (busy_z && n < 100) begin
      n++;
      tick();
    end
    check("reset_busy_cycles", 64'(n), 64'd32);
    all_zero("reset_all_zero");

    // Write then read on both ports.
    tick();
    regWrite = 1'b1; writeReg = 5'd7; writeData = 32'hDEADBEEF;
    tick();
    regWrite = 1'b0; readReg = {5'd7, 5'd7};
    #2;
    check("rd7_both_ports", rd_z, 64'hDEADBEEF_DEADBEEF);

    // Same-cycle bypass.
    tick();
    regWrite = 1'b1; writeReg = 5'd3; writeData = 32'h12345678;
    readReg = {5'd7, 5'd3};
    #2;
    check("bypass_rd3", rd_z, 64'hDEADBEEF_12345678);

    // Writes to entry 0.
    tick();
    regWrite = 1'b1; writeReg = 5'd0; writeData = 32'hFFFFFFFF;
    readReg = {5'd3, 5'd0};
    #2;
    check("zero_bypass_z", rd_z, 64'h12345678_00000000);
    check("zero_bypass_nz", rd_nz, 64'h12345678_FFFFFFFF);
    tick();
    regWrite = 1'b0;
    #2;
    check("zero_rd_z", rd_z, 64'h12345678_00000000);
    check("zero_rd_nz", rd_nz, 64'h12345678_FFFFFFFF);

    // Fill 1..31.
    for (int i = 1; i < 32; i++) begin
      tick();
      regWrite = 1'b1; writeReg = 5'(i);
      writeData = 32'hA5000000 ^ (32'(i) * 32'h01010101);
      readReg = {5'(i - 1), 5'(i)};
    end
    tick();
    regWrite = 1'b0; readReg = {5'd31, 5'd5};
    #2;
    check("fill_rd5_rd31", rd_z, 64'hBA1F1F1F_A0050505);

    // Clear with a write in the same cycle, plus a write and clearReq mid-sweep.
    tick();
    regWrite = 1'b1; writeReg = 5'd9; writeData = 32'h00000099;
    clearReq = 1'b1; readReg = {5'd5, 5'd9};
    #2;
    check("clear_cycle_bypass", rd_z, 64'hA0050505_00000099);
    tick();
    regWrite = 1'b0; clearReq = 1'b0;
    n = 0;
    while (busy_z && n < 100) begin
      n++;
      if (n == 5) begin
        regWrite = 1'b1; writeReg = 5'd4; writeData = 32'h00000BAD; clearReq = 1'b1;
      end else begin
        regWrite = 1'b0; clearReq = 1'b0;
      end
      tick();
    end
    regWrite = 1'b0; clearReq = 1'b0;
    check("clear_busy_cycles", 64'(n), 64'd32);
    all_zero("clear_all_zero");

    // Reset at sweep cycle 10 restarts the sweep.
    tick();
    regWrite = 1'b1; writeReg = 5'd2; writeData = 32'h00000022;
    tick();
    regWrite = 1'b0; clearReq = 1'b1;
    tick();
    clearReq = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1; readReg = {5'd2, 5'd2};
    #2;
    check("midreset_rd", rd_z, 64'h0);
    tick();
    reset = 1'b0;
    check("midreset_busy", {63'd0, busy_z}, 64'd1);
    m = 0;
    while (busy_z && m < 100) begin
      m++;
      tick();
    end
    check("midreset_busy_cycles", 64'(m), 64'd32);
    all_zero("midreset_all_zero");

    // Mixed writes with trailing reads; the per-cycle model check covers these.
    prev = 5'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      a = 5'(i * 4 + 1);
      regWrite = 1'b1; writeReg = a; writeData = $urandom;
      readReg = {a, prev};
      prev = a;
    end
    tick();
    regWrite = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
